// File: rtl/alu_pkg.sv
// Shared opcode and arbiter-state encodings for the shared-ALU slice.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLT = 4'b0100,
        ALU_SUB = 4'b0110
    } alu_op_e;

    // Result reported for an op code the ALU does not implement
    localparam logic [31:0] ALU_ERR_VAL = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic is_legal_op(alu_op_e op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLT, ALU_SUB: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU (add, sub, and, or, xor, signed set-less-than).
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  alu_control_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    // Select the operation; unknown codes yield zero here and are flagged by the caller
    always_comb begin
        case (alu_control_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLT: result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
            ALU_SUB: result_o = a_i - b_i;
            default: result_o = 32'b0;
        endcase
    end

    assign zero_o = (result_o == 32'b0);

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first set request scanning last+1, last+2, ... mod N.
// Latency: purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    // Scan from lowest to highest priority so the nearest requester after last wins
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % N]) begin
                idx_o = IW'((int'(last_i) + k) % N);
                any_o = 1'b1;
            end
        end
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters with round-robin grant and registered result.
// Latency: accept in cycle c, response valid from cycle c+2; one op in flight at a time.
// Backpressure: response held until rsp_ready of the granted requester; no accepts meanwhile.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*4-1:0]    req_op,
    input  logic [N_REQ*XLEN-1:0] req_a,
    input  logic [N_REQ*XLEN-1:0] req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]       rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e       state_q;
    logic [IW-1:0]    gnt_idx_q, last_gnt_q;
    logic [3:0]       op_q;
    logic [XLEN-1:0]  a_q, b_q, result_q;
    logic             zero_q, err_q, busy_q;
    logic [N_REQ-1:0] rsp_valid_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [3:0]       op_d;
    logic [XLEN-1:0]  a_d, b_d, result_d, alu_result;
    logic             zero_d, err_d, alu_zero;

    rr_picker #(.N(N_REQ)) u_picker (
        .req_i  (req_valid),
        .last_i (last_gnt_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Winner's operands, captured only on the accept edge
    assign op_d = req_op[int'(pick_idx) * 4 +: 4];
    assign a_d  = req_a[int'(pick_idx) * XLEN +: XLEN];
    assign b_d  = req_b[int'(pick_idx) * XLEN +: XLEN];

    alu u_alu (
        .a_i           (a_q),
        .b_i           (b_q),
        .alu_control_i (op_q),
        .result_o      (alu_result),
        .zero_o        (alu_zero)
    );

    // Illegal codes override the ALU output; the marker value is non-zero so zero drops
    assign err_d    = !is_legal_op(alu_op_e'(op_q));
    assign result_d = err_d ? ALU_ERR_VAL : alu_result;
    assign zero_d   = err_d ? 1'b0 : alu_zero;

    // Accept is a same-cycle pulse; masked in reset so stray valids never look granted
    assign req_ready = (rst_n && state_q == IDLE) ? pick_gnt : '0;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;

    // Arbiter FSM: accept -> compute -> hold response until the granted requester takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            last_gnt_q  <= IW'(N_REQ - 1);
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        op_q       <= op_d;
                        a_q        <= a_d;
                        b_q        <= b_d;
                        gnt_idx_q  <= pick_idx;
                        last_gnt_q <= pick_idx;
                        busy_q     <= 1'b1;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= result_d;
                    zero_q      <= zero_d;
                    err_q       <= err_d;
                    rsp_valid_q <= N_REQ'(1) << gnt_idx_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_idx_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then randomized transactions.
// Latency: n/a.
// Backpressure: bench drives rsp_ready stalls of varying length.
module tb_alu_arbiter;

    localparam int N    = 3;
    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*4-1:0]    req_op = '0;
    logic [N*XLEN-1:0] req_a = '0;
    logic [N*XLEN-1:0] req_b = '0;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready = '0;
    logic [XLEN-1:0]   rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic              busy;

    int tests = 0;
    int fails = 0;
    int model_last = N - 1;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU straight from the opcode table: {err, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'b0010: return {1'b0, a + b};
            4'b0110: return {1'b0, a - b};
            4'b0000: return {1'b0, a & b};
            4'b0001: return {1'b0, a | b};
            4'b0011: return {1'b0, a ^ b};
            4'b0100: return {1'b0, 31'b0, ($signed(a) < $signed(b))};
            default: return {1'b1, 32'hDEADBEEF};
        endcase
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]          = v;
        req_op[i*4 +: 4]      = op;
        req_a[i*XLEN +: XLEN] = a;
        req_b[i*XLEN +: XLEN] = b;
    endtask

    task automatic rand_inputs(input bit keep_valid);
        for (int i = 0; i < N; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            case ($urandom_range(0, 7))
                0: op = 4'b0010;
                1: op = 4'b0110;
                2: op = 4'b0000;
                3: op = 4'b0001;
                4: op = 4'b0011;
                5: op = 4'b0100;
                default: op = 4'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            set_req(i, keep_valid ? req_valid[i] : ($urandom_range(0, 3) != 0), op, a, b);
        end
    endtask

    // One full transaction from the current IDLE cycle; returns in the next IDLE cycle
    task automatic txn(input int stall, input bit scramble);
        int          w;
        logic [N-1:0] oh;
        logic [32:0] exp_r;
        #1;
        if (req_valid == '0) begin
            check("idle_ready", req_ready, '0);
            check("idle_busy", busy, 0);
            tick();
            return;
        end
        w     = rr_pick(model_last, req_valid);
        oh    = N'(1) << w;
        exp_r = alu_ref(req_op[w*4 +: 4], req_a[w*XLEN +: XLEN], req_b[w*XLEN +: XLEN]);
        check("accept_ready", req_ready, oh);
        check("accept_busy", busy, 0);
        check("accept_rspv", rsp_valid, '0);
        model_last = w;
        tick();
        if (scramble) rand_inputs(1'b1);
        #1;
        check("exec_ready", req_ready, '0);
        check("exec_busy", busy, 1);
        check("exec_rspv", rsp_valid, '0);
        tick();
        for (int s = 0; s <= stall; s++) begin
            rsp_ready    = N'($urandom);
            rsp_ready[w] = (s == stall);
            #1;
            check("resp_valid", rsp_valid, oh);
            check("resp_result", rsp_result, exp_r[31:0]);
            check("resp_zero", rsp_zero, (exp_r[31:0] == 32'b0));
            check("resp_err", rsp_err, exp_r[32]);
            check("resp_ready", req_ready, '0);
            check("resp_busy", busy, 1);
            tick();
        end
        rsp_ready = '0;
    endtask

    // Reset while in EXEC (depth 1) or RESP (depth 2); round-robin must restart at r0
    task automatic reset_mid(input int depth);
        set_req(0, 1'b1, 4'b0010, 32'd10, 32'd20);
        set_req(1, 1'b0, 4'b0010, 32'd1, 32'd1);
        set_req(2, 1'b0, 4'b0010, 32'd1, 32'd1);
        #1;
        check("rst_accept", req_ready, N'(1));
        model_last = 0;
        tick();
        if (depth == 2) begin
            tick();
            #1;
            check("rst_resp_v", rsp_valid, N'(1));
            check("rst_resp_r", rsp_result, 32'd30);
        end
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        tick();
        check("rst_rspv", rsp_valid, '0);
        check("rst_busy", busy, 0);
        check("rst_result", rsp_result, 0);
        check("rst_zero", rsp_zero, 0);
        check("rst_err", rsp_err, 0);
        check("rst_ready", req_ready, '0);
        rst_n      = 1'b1;
        rsp_ready  = '0;
        model_last = N - 1;
        set_req(0, 1'b1, 4'b0001, 32'h0F0, 32'h00F);
        set_req(1, 1'b1, 4'b0010, 32'd7, 32'd8);
        set_req(2, 1'b0, 4'b0010, 32'd0, 32'd0);
        txn(0, 1'b0);
    endtask

    initial begin
        // Reset with garbage on the request/response inputs
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        tick();
        tick();
        check("reset_ready", req_ready, '0);
        check("reset_rspv", rsp_valid, '0);
        check("reset_result", rsp_result, 0);
        check("reset_zero", rsp_zero, 0);
        check("reset_err", rsp_err, 0);
        check("reset_busy", busy, 0);
        rst_n      = 1'b1;
        rsp_ready  = '0;
        model_last = N - 1;

        // Contention straight out of reset: r0 SUB 3-3, r1 SLT -1<1; r0, r1, then r0 again
        set_req(0, 1'b1, 4'b0110, 32'd3, 32'd3);
        set_req(1, 1'b1, 4'b0100, 32'hFFFF_FFFF, 32'd1);
        set_req(2, 1'b0, 4'b0000, 32'd0, 32'd0);
        txn(0, 1'b0);
        txn(0, 1'b0);
        txn(0, 1'b0);

        // Single requester ADD 5+7
        set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7);
        set_req(1, 1'b0, 4'b0100, 32'd0, 32'd0);
        txn(0, 1'b0);

        // Backpressure for 10 cycles, then a lone requester is regranted immediately
        set_req(0, 1'b1, 4'b0001, 32'h1234_0000, 32'h0000_5678);
        txn(10, 1'b0);
        txn(1, 1'b0);

        // Illegal op code
        set_req(0, 1'b1, 4'b1111, 32'd1, 32'd1);
        txn(0, 1'b0);

        // Operands changed after accept must not affect the result
        set_req(0, 1'b0, 4'b0010, 32'd0, 32'd0);
        set_req(2, 1'b1, 4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        txn(2, 1'b1);

        // Reset in EXEC and in RESP
        reset_mid(1);
        reset_mid(2);

        // All requesters valid: strict rotation
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 4'b0010, 32'(i), 32'd100);
        for (int t = 0; t < 2 * N; t++) txn(0, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            rand_inputs(1'b0);
            txn($urandom_range(0, 3), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
